// File: rtl/vector_addsub_pkg.sv
// Shared types and constants for the vector add/sub pipeline.
// Lane opcode encoding and the legal range of the pipeline depth parameter.
package vector_addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

endpackage

// File: rtl/vector_addsub_lane.sv
// Single-lane W-bit add/subtract with carry/not-borrow and signed overflow flags.
// Build option: VECTOR_ADDSUB_SAT_EN clamps y_o to the signed limits on overflow.
module vector_addsub_lane
  import vector_addsub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  op_e          op_i,
  output logic [W-1:0] y_o,
  output logic         cout_o,
  output logic         ovf_o
);

  logic [W-1:0] b_eff;
  logic [W:0]   sum;
  logic [W-1:0] raw;
  logic         is_sub;

  // Subtraction is a + ~b + 1, so cout is the unsigned not-borrow.
  assign is_sub = (op_i == OP_SUB);
  assign b_eff  = is_sub ? ~b_i : b_i;
  assign sum    = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, is_sub};
  assign raw    = sum[W-1:0];
  assign cout_o = sum[W];
  assign ovf_o  = (a_i[W-1] == b_eff[W-1]) && (raw[W-1] != a_i[W-1]);

`ifdef VECTOR_ADDSUB_SAT_EN
  // On overflow both operands share a's sign, which picks the limit.
  assign y_o = ovf_o ? (a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : raw;
`else
  assign y_o = raw;
`endif

endmodule

// File: rtl/vector_addsub_pipe.sv
// N-lane add/subtract pipeline, STAGES deep, with per-stage valid and back-pressure.
// Build option: VECTOR_ADDSUB_SAT_EN (saturating lane results).
module vector_addsub_pipe
  import vector_addsub_pkg::*;
#(
  parameter int W      = 8,
  parameter int N      = 4,
  parameter int STAGES = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_op,
  input  logic [W-1:0] a [N],
  input  logic [W-1:0] b [N],
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y [N],
  output logic [N-1:0] cout,
  output logic [N-1:0] ovf
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("vector_addsub_pipe: STAGES out of range");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and ready may depend on valid.
  logic [STAGES-1:0] valid_q;
  op_e               op_q  [STAGES];
  logic [W-1:0]      a_q   [STAGES][N];
  logic [W-1:0]      b_q   [STAGES][N];

  logic [STAGES-1:0] src_valid_d;
  op_e               src_op_d [STAGES];
  logic [W-1:0]      src_a_d  [STAGES][N];
  logic [W-1:0]      src_b_d  [STAGES][N];
  logic [STAGES-1:0] ready_d;

  // A stage can load when it is empty or its content moves on this edge.
  always_comb begin
    logic r;
    ready_d = '0;
    r       = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r          = !valid_q[k] || r;
      ready_d[k] = r;
    end
  end

  always_comb begin
    src_valid_d    = '0;
    src_valid_d[0] = in_valid;
    src_op_d[0]    = op_e'(in_op);
    for (int i = 0; i < N; i++) begin
      src_a_d[0][i] = a[i];
      src_b_d[0][i] = b[i];
    end
    for (int k = 1; k < STAGES; k++) begin
      src_valid_d[k] = valid_q[k-1];
      src_op_d[k]    = op_q[k-1];
      for (int i = 0; i < N; i++) begin
        src_a_d[k][i] = a_q[k-1][i];
        src_b_d[k][i] = b_q[k-1][i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        op_q[k] <= OP_ADD;
        for (int i = 0; i < N; i++) begin
          a_q[k][i] <= '0;
          b_q[k][i] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ready_d[k]) begin
          valid_q[k] <= src_valid_d[k];
          op_q[k]    <= src_op_d[k];
          for (int i = 0; i < N; i++) begin
            a_q[k][i] <= src_a_d[k][i];
            b_q[k][i] <= src_b_d[k][i];
          end
        end
      end
    end
  end

  assign in_ready  = ready_d[0] && !reset;
  assign out_valid = valid_q[STAGES-1];

  // Operands ride the pipe; the lanes evaluate from the final stage registers.
  for (genvar i = 0; i < N; i++) begin : g_lane
    vector_addsub_lane #(.W(W)) u_lane (
      .a_i    (a_q[STAGES-1][i]),
      .b_i    (b_q[STAGES-1][i]),
      .op_i   (op_q[STAGES-1]),
      .y_o    (y[i]),
      .cout_o (cout[i]),
      .ovf_o  (ovf[i])
    );
  end

endmodule

// File: tb/tb_vector_addsub_pipe.sv
// Directed and scoreboarded bench for vector_addsub_pipe (W=8, N=4, STAGES=2).
// Expected values follow VECTOR_ADDSUB_SAT_EN when it is defined.
module tb_vector_addsub_pipe;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_op = 1'b0;
  logic [7:0] a [4];
  logic [7:0] b [4];
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] y [4];
  logic [3:0] cout;
  logic [3:0] ovf;

  int n_vec = 0;
  int n_err = 0;
  int n_in  = 0;
  int n_out = 0;
  bit mon_en = 1'b0;
  bit hold_chk = 1'b0;
  logic [39:0] held;
  logic [39:0] exp_q[$];

  vector_addsub_pipe #(.W(8), .N(4), .STAGES(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] observed();
    logic [39:0] r;
    r = {ovf, cout, 32'h0};
    for (int i = 0; i < 4; i++) r[8*i +: 8] = y[i];
    return r;
  endfunction

  // Reference using signed/unsigned integer arithmetic on {ovf, cout, y}.
  function automatic logic [39:0] model(input logic op, input logic [31:0] av, input logic [31:0] bv);
    logic [39:0] r;
    int ua, ub, sa, sb, s;
    logic [7:0] yy;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      ua = int'(av[8*i +: 8]);
      ub = int'(bv[8*i +: 8]);
      sa = (ua > 127) ? ua - 256 : ua;
      sb = (ub > 127) ? ub - 256 : ub;
      s  = op ? sa - sb : sa + sb;
      r[32+i] = op ? (ua >= ub) : (ua + ub > 255);
      r[36+i] = (s > 127) || (s < -128);
      yy = s[7:0];
`ifdef VECTOR_ADDSUB_SAT_EN
      if (r[36+i]) yy = (s > 0) ? 8'h7F : 8'h80;
`endif
      r[8*i +: 8] = yy;
    end
    return r;
  endfunction

  task automatic drive_ab(input logic [31:0] av, input logic [31:0] bv);
    for (int i = 0; i < 4; i++) begin
      a[i] = av[8*i +: 8];
      b[i] = bv[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] cur_a();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = a[i];
    return r;
  endfunction

  function automatic logic [31:0] cur_b();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  // One clock with monitor: inputs are already set; observe, then advance.
  task automatic step();
    logic [39:0] obs;
    #1;
    obs = observed();
    if (mon_en) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_op, cur_a(), cur_b()));
        n_in++;
      end
      if (hold_chk) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", obs, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
        else chk("result", obs, exp_q.pop_front());
        n_out++;
      end
      hold_chk = out_valid && !out_ready;
      held     = obs;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send_one(input string tag, input logic op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [39:0] expv);
    int lat;
    in_op = op;
    drive_ab(av, bv);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 2);
    chk(tag, observed(), expv);
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit saw;
    logic [39:0] e_ovf, e_sub;
    for (int i = 0; i < 4; i++) begin
      a[i] = '0;
      b[i] = '0;
    end

    // Reset state
    repeat (2) begin
      @(posedge clock);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_outputs", observed(), 0);
    end
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clock);
    #1;

    // Directed arithmetic
`ifdef VECTOR_ADDSUB_SAT_EN
    e_ovf = 40'h560080007F;
    e_sub = 40'hC67F8002FE;
`else
    e_ovf = 40'h5600000080;
    e_sub = 40'hC6807F02FE;
`endif
    send_one("add_basic", 1'b0, 32'h04030201, 32'h281E140A, 40'h002C21160B);
    send_one("add_ovf_carry", 1'b0, 32'h0080FF7F, 32'h00800101, e_ovf);
    send_one("sub_borrow_ovf", 1'b1, 32'h7F800705, 32'hFF010507, e_sub);

    // Stream of 10 with a stall window
    mon_en = 1'b1; hold_chk = 1'b0; n_in = 0; n_out = 0;
    for (int c = 0; c < 60; c++) begin
      in_valid  = (n_in < 10);
      in_op     = n_in[0];
      drive_ab({8'(n_in*37+3), 8'(n_in*37+2), 8'(n_in*37+1), 8'(n_in*37)},
               {8'(n_in*53+230), 8'(n_in*53+7), 8'(n_in*53+150), 8'(n_in*53+9)});
      out_ready = !(c >= 3 && c <= 8);
      if (c == 6) begin
        #1;
        chk("full_in_ready", in_ready, 0);
      end
      step();
      if (n_out == 10) break;
    end
    in_valid = 1'b0;
    chk("stream_out_count", n_out, 10);
    repeat (4) step();
    chk("stream_no_dup", n_out, 10);
    chk("stream_q_empty", exp_q.size(), 0);

    // Reset with two vectors in flight
    hold_chk = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 1'b0;
    drive_ab(32'h11111111, 32'h22222222);
    step();
    drive_ab(32'h33333333, 32'h44444444);
    step();
    mon_en = 1'b0;
    exp_q.delete();
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clock);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_outputs", observed(), 0);
    reset = 1'b0;
    out_ready = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(posedge clock);
      #1;
      if (out_valid) saw = 1'b1;
    end
    chk("midrst_no_ghost", saw, 0);
    send_one("post_rst_add", 1'b0, 32'h0A141E28, 32'h05050505, 40'h000F19232D);

    // Full-rate throughput
    mon_en = 1'b1; hold_chk = 1'b0; n_in = 0; n_out = 0;
    repeat (20) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_op     = 1'($urandom_range(0, 1));
      drive_ab($urandom, $urandom);
      step();
    end
    chk("tput_in", n_in, 20);
    chk("tput_out", n_out, 18);
    in_valid = 1'b0;
    repeat (4) step();
    chk("tput_q_empty", exp_q.size(), 0);

    // Random handshakes
    repeat (300) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_op     = 1'($urandom_range(0, 1));
      drive_ab($urandom, $urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    hold_chk  = 1'b0;
    repeat (6) step();
    chk("rand_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vector_addsub_pipe.md
VECTOR_ADDSUB_PIPE -- requirements
Module: vector_addsub_pipe

Interface
REQ-001 Parameter W, default 8, lane width in bits (legal range 2..64).
REQ-002 Parameter N, default 4, lane count (legal range 1..32).
REQ-003 Parameter STAGES, default 2, pipeline depth in registered stages (legal range 1..4).
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  an operand vector is presented.
REQ-007 in_ready  output  1  the block accepts the vector this cycle.
REQ-008 in_op  input  1  0 = add (a+b), 1 = subtract (a-b); applies to all lanes.
REQ-009 a  input  [W-1:0] x N unpacked  lane operands A.
REQ-010 b  input  [W-1:0] x N unpacked  lane operands B.
REQ-011 out_valid  output  1  a result vector is presented.
REQ-012 out_ready  input  1  the consumer accepts the result this cycle.
REQ-013 y  output  [W-1:0] x N unpacked  lane results.
REQ-014 cout  output  [N-1:0]  per-lane carry-out (add) or not-borrow (sub), unsigned sense.
REQ-015 ovf  output  [N-1:0]  per-lane signed two's-complement overflow.

Function
REQ-016 An input transfer occurs iff in_valid && in_ready; an output transfer occurs iff out_valid && out_ready.
REQ-017 Each transfer's result appears on y/cout/ovf exactly STAGES cycles after acceptance when no stall occurs.
REQ-018 Stage k holds a valid bit; stage k advances when stage k+1 is empty or advancing; the last stage advances on out_ready.
REQ-019 in_ready = !valid[0] || stage 0 advances (combinational from downstream, no extra register).
REQ-020 Empty stages (bubbles) collapse; sustained throughput is one vector per cycle with out_ready held high.
REQ-021 Lane i arithmetic: {cout[i], y[i]} = a[i] + (op ? ~b[i] : b[i]) + op, computed at W+1 bits and truncated to W for y.
REQ-022 ovf[i] = 1 iff the operands' sign bits are equal (after b inversion for sub) and y[i]'s sign differs.
REQ-023 Operands and op are registered in stage 0; arithmetic completes by the final stage; intermediate stages only carry data and valid.
REQ-024 While out_valid && !out_ready, y/cout/ovf/out_valid hold stable until the transfer.
REQ-025 When all stages are full and out_ready=0, in_ready=0 and no input is lost or overwritten.
REQ-026 A simultaneous input and output transfer on a full pipeline is accepted without a bubble.
REQ-027 Lanes are independent; no carry propagates between lanes.

Reset
REQ-028 While reset=1: all valid bits clear, out_valid=0, in_ready=0; data registers clear to 0, so y=0, cout=0, ovf=0.
REQ-029 in_ready=1 from the first cycle after reset deasserts.
REQ-030 Reset mid-operation discards all in-flight vectors; no result for them is ever presented.

Configuration
REQ-031 Macro VECTOR_ADDSUB_SAT_EN: when defined, y[i] saturates to the signed limits (2^(W-1)-1 or -2^(W-1)) whenever ovf[i]=1; ovf and cout still report the unsaturated event.
REQ-032 When VECTOR_ADDSUB_SAT_EN is undefined, y[i] wraps modulo 2^W, with no saturation logic present.

Structure
REQ-033 Package vector_addsub_pkg holds the op typedef (OP_ADD=0, OP_SUB=1) and the STAGES legal-range constants.
REQ-034 One sub-module, vector_addsub_lane, implements single-lane add/sub/flags/saturation; the top generates N instances plus the pipeline and handshake logic.

Verification
REQ-035 W=8,N=4,STAGES=2, add a={1,2,3,4} b={10,20,30,40}, out_ready=1 -> y={11,22,33,44} two cycles later, cout=0, ovf=0.
REQ-036 add a[0]=8'h7F b[0]=8'h01 -> y[0]=8'h80, ovf[0]=1 (8'h7F with SAT_EN); add 8'hFF+8'h01 -> y=8'h00, cout=1, ovf=0.
REQ-037 sub a[0]=5 b[0]=7 -> y[0]=8'hFE, cout[0]=0; sub 7-5 -> y=2, cout=1.
REQ-038 Stream 10 vectors, out_ready=0 for cycles 3..8 -> in_ready falls once 2 stages are full; all 10 results emerge in order, none lost or duplicated, y stable while stalled.
REQ-039 Assert reset with 2 vectors in flight -> out_valid=0 next cycle; neither result ever appears; a new vector after reset returns correctly.
REQ-040 Random in_valid/out_ready, random ops, STAGES in {1,4}, N in {1,8} -> scoreboard matches the reference model, and throughput is 1 per cycle whenever both handshake signals are held high.
